led_frame_sequencer: RTL

Frame-level controller that drives the pixel-select address of the registered RGB mux and streams the selected 24-bit colour words, one per LED, to the downstream LED serializer through a valid/ready handshake. On a start pulse it walks addresses 0..NUM_LEDS-1 and absorbs the mux's one-cycle read latency. After the last pixel it holds a latch/reset gap before reporting frame completion. It sits between the colour-capture logic and the LED line driver.

---
 rtl/led_frame_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer
//
// Frame-level controller for an addressable LED string. On a start pulse it walks the pixel
// select address 0..NUM_LEDS-1 into a registered RGB mux. It waits out the mux's one-cycle
// read latency, then offers each 24-bit colour word to the LED serializer over a
// valid/ready handshake. After the last pixel it holds a latch/reset gap of GAP_CYCLES cycles
// and pulses frame_done as the gap ends.
//
// Optional feature: define LED_SEQ_AUTO_REPEAT_EN to restart the next frame directly from
// the end of the gap (FETCH, addr=0) instead of returning to IDLE. With it enabled, only
// the first frame after reset needs a start pulse.
//
// Ports:
//   clk         in   1   system clock, rising edge
//   rst         in   1   asynchronous active-high reset
//   start       in   1   frame request, sampled only in IDLE
//   addr        out  6   pixel select to the RGB mux (registered)
//   chosen_data in  24   mux output, valid one cycle after addr
//   pix_data    out 24   colour word to the serializer (registered)
//   pix_valid   out  1   pix_data valid
//   pix_ready   in   1   serializer accepts pix_data
//   busy        out  1   high in every state except IDLE
//   gap_active  out  1   high during the post-frame gap
//   frame_done  out  1   one-cycle pulse on the cycle the gap has ended

module led_frame_sequencer #(
    parameter int unsigned NUM_LEDS   = 25,
    parameter int unsigned GAP_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [5:0]  addr,
    input  logic [23:0] chosen_data,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        gap_active,
    output logic        frame_done
);

    // Counter must be at least one bit wide even for a single-cycle gap.
    localparam int unsigned CntW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [5:0]      LastAddr = 6'(NUM_LEDS - 1);
    localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPresent,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [5:0]      addr_q, addr_d;
    logic [23:0]     data_q, data_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = StFetch;
                end
            end
            // addr is held here so the mux can register the selected pixel.
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                data_d  = chosen_data;
                valid_d = 1'b1;
                state_d = StPresent;
            end
            StPresent: begin
                if (valid_q && pix_ready) begin
                    valid_d = 1'b0;
                    if (addr_q == LastAddr) begin
                        cnt_d   = GapLoad;
                        state_d = StGap;
                    end else begin
                        addr_d  = addr_q + 6'd1;
                        state_d = StFetch;
                    end
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    addr_d  = '0;
`ifdef LED_SEQ_AUTO_REPEAT_EN
                    state_d = StFetch;
`else
                    state_d = StIdle;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign addr       = addr_q;
    assign pix_data   = data_q;
    assign pix_valid  = valid_q;
    assign frame_done = done_q;
    assign busy       = (state_q != StIdle);
    assign gap_active = (state_q == StGap);

endmodule
